// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared code width, blank code and scan state encoding.
package seg_display_pkg;
   localparam int CODE_W = 5;
   localparam logic [CODE_W-1:0] CODE_BLANK = 5'b00000;
   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_BLANK} state_t;
endpackage

// File: rtl/seg_scan_tick.sv
// seg_scan_tick: CLK_DIV-cycle prescaler with synchronous clear and terminal-count tick.
module seg_scan_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int CW = $clog2(CLK_DIV + 1);
   logic [CW-1:0] cnt;
   assign tick = (cnt == CW'(CLK_DIV - 1));
   always_ff @(posedge clk)
      if (reset || clear || tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner: time-multiplexed digit scan with tear-free frame loading.
// Define SCAN_BLANK_EN to insert BLANK_CYCLES off-cycles after every digit slot.
module seg_display_scanner
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 4,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         scan_en,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [CODE_W*NUM_DIGITS-1:0] load_data,
   output logic [CODE_W-1:0]            dec_code,
   output logic [NUM_DIGITS-1:0]        digit_en,
   output logic                         frame_done
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = CODE_W * NUM_DIGITS;
`ifdef SCAN_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif
   state_t state, state_nxt;
   logic [IW-1:0] idx, idx_nxt, idx_inc;
   logic [FW-1:0] active, pending, frame_nxt;
   logic [NUM_DIGITS-1:0] en_nxt;
   logic [CODE_W-1:0] code_nxt;
   logic done_nxt, tick, btick, step, wrap, commit, take;
   seg_scan_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk(clk), .reset(reset), .clear(state != ST_SCAN || !scan_en), .tick(tick)
   );
   seg_scan_tick #(.CLK_DIV(BLANK_CYCLES)) u_blank (
      .clk(clk), .reset(reset), .clear(state != ST_BLANK || !scan_en), .tick(btick)
   );
   // step = end of a digit slot; the wrap step is the frame boundary where a pending frame commits
   always_comb begin
      take      = load_valid && load_ready;
      step      = scan_en && (BLANK_EN ? (state == ST_BLANK && btick) : (state == ST_SCAN && tick));
      wrap      = step && idx == IW'(NUM_DIGITS - 1);
      commit    = !load_ready && (wrap || state == ST_IDLE);
      frame_nxt = commit ? pending : active;
      idx_inc   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      state_nxt = state;
      idx_nxt   = idx;
      en_nxt    = digit_en;
      code_nxt  = dec_code;
      done_nxt  = 1'b0;
      if (!scan_en) begin
         state_nxt = ST_IDLE;
         idx_nxt   = '0;
         en_nxt    = '0;
      end else if (state == ST_IDLE) begin
         state_nxt = ST_SCAN;
         idx_nxt   = '0;
         en_nxt    = NUM_DIGITS'(1);
         code_nxt  = frame_nxt[CODE_W-1:0];
      end else if (step) begin
         state_nxt = ST_SCAN;
         idx_nxt   = idx_inc;
         en_nxt    = NUM_DIGITS'(1) << idx_inc;
         code_nxt  = frame_nxt[CODE_W*idx_inc +: CODE_W];
         done_nxt  = wrap;
      end else if (BLANK_EN && state == ST_SCAN && tick) begin
         state_nxt = ST_BLANK;
         en_nxt    = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         idx        <= '0;
         digit_en   <= '0;
         dec_code   <= CODE_BLANK;
         frame_done <= 1'b0;
         load_ready <= 1'b1;
         active     <= {NUM_DIGITS{CODE_BLANK}};
         pending    <= {NUM_DIGITS{CODE_BLANK}};
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         digit_en   <= en_nxt;
         dec_code   <= code_nxt;
         frame_done <= done_nxt;
         load_ready <= take ? 1'b0 : (commit ? 1'b1 : load_ready);
         active     <= frame_nxt;
         pending    <= take ? load_data : pending;
      end
   end
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: directed vector table plus hand sequences for seg_display_scanner.
module tb_seg_display_scanner;
   localparam int ND = 4;
`ifdef SCAN_BLANK_EN
   localparam int SLOT = 4;
`else
   localparam int SLOT = 3;
`endif
   localparam int FP = ND * SLOT;
   localparam int NROW = 3 * FP + 5;
   localparam logic [19:0] F1 = 20'h8C421;
   localparam logic [19:0] F2 = 20'h7A5F6;
   localparam logic [19:0] F3 = 20'h1D2E9;
   localparam logic [19:0] BAD = 20'hFFFFF;
   typedef struct {
      logic        sc;
      logic        lv;
      logic [19:0] ld;
      logic [3:0]  en;
      logic [4:0]  code;
      logic        fd;
      logic        lr;
   } vec_t;
   logic clk = 1'b0;
   logic reset, scan_en, load_valid, load_ready, frame_done;
   logic [19:0] load_data;
   logic [4:0] dec_code;
   logic [3:0] digit_en;
   int tests = 0;
   int fails = 0;
   vec_t vecs[64];
   always #5 clk = ~clk;
   seg_display_scanner #(.NUM_DIGITS(ND), .CLK_DIV(3), .BLANK_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .scan_en(scan_en), .load_valid(load_valid),
      .load_ready(load_ready), .load_data(load_data), .dec_code(dec_code),
      .digit_en(digit_en), .frame_done(frame_done)
   );
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [4:0] code_of(input logic [19:0] f, input int d);
      return f[5*d +: 5];
   endfunction
   initial begin
      int d;
      logic [19:0] f;
      bit found;
      for (int r = 0; r < NROW; r++) begin
         d = (r / SLOT) % ND;
         f = (r < FP) ? F1 : (r < 3 * FP) ? F2 : F3;
         vecs[r].sc   = 1'b1;
         vecs[r].lv   = (r == 5 || r == 8 || r == 2 * FP);
         vecs[r].ld   = (r == 5) ? F2 : (r == 8) ? BAD : F3;
         vecs[r].en   = (r % SLOT < 3) ? (4'b0001 << d) : 4'b0000;
         vecs[r].code = code_of(f, d);
         vecs[r].fd   = (r > 0 && r % FP == 0);
         vecs[r].lr   = !((r >= 5 && r < FP) || (r >= 2 * FP && r < 3 * FP));
      end
      reset = 1'b1; scan_en = 1'b1; load_valid = 1'b0; load_data = '0;
      for (int i = 0; i < 2; i++) begin
         step;
         chk("reset digit_en", digit_en, 0);
         chk("reset load_ready", load_ready, 1);
         chk("reset dec_code", dec_code, 0);
         chk("reset frame_done", frame_done, 0);
      end
      reset = 1'b0; scan_en = 1'b0; load_valid = 1'b1; load_data = F1;
      step;
      chk("idle take load_ready", load_ready, 0);
      chk("idle digit_en", digit_en, 0);
      load_valid = 1'b0;
      step;
      chk("idle commit load_ready", load_ready, 1);
      chk("idle dec_code", dec_code, 0);
      for (int r = 0; r < NROW; r++) begin
         scan_en = vecs[r].sc; load_valid = vecs[r].lv; load_data = vecs[r].ld;
         step;
         chk($sformatf("row%0d digit_en", r), digit_en, vecs[r].en);
         chk($sformatf("row%0d dec_code", r), dec_code, vecs[r].code);
         chk($sformatf("row%0d frame_done", r), frame_done, vecs[r].fd);
         chk($sformatf("row%0d load_ready", r), load_ready, vecs[r].lr);
      end
      load_valid = 1'b0; scan_en = 1'b1; found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step;
         found = (digit_en == 4'b0100);
      end
      chk("reach digit 2", found, 1);
      scan_en = 1'b0;
      step;
      chk("scan off digit_en", digit_en, 0);
      chk("scan off frame_done", frame_done, 0);
      step;
      chk("scan off hold digit_en", digit_en, 0);
      scan_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         chk($sformatf("restart dwell%0d digit_en", i), digit_en, 4'b0001);
         chk($sformatf("restart dwell%0d dec_code", i), dec_code, code_of(F3, 0));
      end
      step;
      chk("restart next slot digit_en", digit_en, (SLOT == 3) ? 4'b0010 : 4'b0000);
      load_valid = 1'b1; load_data = F2;
      step;
      chk("mid-frame take load_ready", load_ready, 0);
      load_valid = 1'b0; reset = 1'b1;
      step;
      chk("mid reset load_ready", load_ready, 1);
      chk("mid reset digit_en", digit_en, 0);
      chk("mid reset dec_code", dec_code, 0);
      reset = 1'b0; scan_en = 1'b0;
      step;
      step;
      scan_en = 1'b1;
      step;
      chk("post reset digit_en", digit_en, 4'b0001);
      chk("post reset pending dropped", dec_code, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
